// File: rtl/gb80_register_file_pkg.sv
// Shared register-file encodings: byte indices, pair indices and pair op codes.
// Also imported by controller_sequencer, so its PC address 3'h3 is PAIR_PC.
package gb80_regfile_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;

  localparam logic [2:0] PAIR_BC = 3'd0;
  localparam logic [2:0] PAIR_DE = 3'd1;
  localparam logic [2:0] PAIR_HL = 3'd2;
  localparam logic [2:0] PAIR_PC = 3'd3;
  localparam logic [2:0] PAIR_SP = 3'd4;

  typedef enum logic [1:0] {
    PAIR_OP_INC  = 2'b00,
    PAIR_OP_DEC  = 2'b01,
    PAIR_OP_LOAD = 2'b10,
    PAIR_OP_HOLD = 2'b11
  } pair_op_t;

endpackage

// File: rtl/gb80_register_file_if.sv
// Register-interface strobes from the controller and the register file's read-back.
interface gb80_register_file_if #(
  parameter int ADDR_LENGTH = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int PTR_WIDTH   = 16
);
  logic [ADDR_LENGTH-1:0] i_reg_addr;
  logic                   i_reg_wr;
  logic                   i_reg_rd;
  logic                   i_pair_wr;
  logic                   i_pair_rd;
  logic [1:0]             i_pair_op;
  logic [DATA_WIDTH-1:0]  i_data_in;
  logic [PTR_WIDTH-1:0]   i_addr_in;
  logic [DATA_WIDTH-1:0]  o_data_out;
  logic                   o_data_valid;
  logic [PTR_WIDTH-1:0]   o_addr_out;
  logic                   o_addr_valid;
  logic                   o_conflict;
  logic [PTR_WIDTH-1:0]   o_pc;

  modport master (
    output i_reg_addr, i_reg_wr, i_reg_rd, i_pair_wr, i_pair_rd, i_pair_op, i_data_in, i_addr_in,
    input  o_data_out, o_data_valid, o_addr_out, o_addr_valid, o_conflict, o_pc
  );

  modport slave (
    input  i_reg_addr, i_reg_wr, i_reg_rd, i_pair_wr, i_pair_rd, i_pair_op, i_data_in, i_addr_in,
    output o_data_out, o_data_valid, o_addr_out, o_addr_valid, o_conflict, o_pc
  );
endinterface

// File: rtl/gb80_register_file_pair_incdec.sv
// Next value for one pointer-width pair: increment, decrement, load or hold (modulo 2^W).
module gb80_pair_incdec
  import gb80_regfile_pkg::*;
#(
  parameter int PTR_WIDTH = 16
) (
  input  logic [PTR_WIDTH-1:0] cur,
  input  pair_op_t             op,
  input  logic [PTR_WIDTH-1:0] load_val,
  output logic [PTR_WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (op)
      PAIR_OP_INC:  nxt = cur + PTR_WIDTH'(1);
      PAIR_OP_DEC:  nxt = cur - PTR_WIDTH'(1);
      PAIR_OP_LOAD: nxt = load_val;
      PAIR_OP_HOLD: nxt = cur;
      default:      nxt = cur;
    endcase
  end

endmodule

// File: rtl/gb80_register_file.sv
// B/C/D/E/H/L byte registers plus PC/SP pointers, with combinational read-back.
// Pair strobes take precedence over byte strobes; a collision is flagged one cycle later.
module gb80_register_file
  import gb80_regfile_pkg::*;
#(
  parameter int                 ADDR_LENGTH = 3,
  parameter int                 DATA_WIDTH  = 8,
  parameter int                 PTR_WIDTH   = 16,
  parameter logic [PTR_WIDTH-1:0] PC_RESET  = 16'h0000,
  parameter logic [PTR_WIDTH-1:0] SP_RESET  = 16'hFFFE
) (
  input logic                i_clk,
  input logic                i_reset_n,
  gb80_register_file_if.slave bus
);

  logic [DATA_WIDTH-1:0] reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
  logic [PTR_WIDTH-1:0]  pc, sp;
  logic                  conflict_q;

  logic                  pair_any;
  logic                  byte_rd_en;
  logic                  byte_wr_en;
  logic [DATA_WIDTH-1:0] byte_sel;
  logic [PTR_WIDTH-1:0]  pair_sel;
  logic [PTR_WIDTH-1:0]  pair_nxt;

  assign pair_any   = bus.i_pair_rd | bus.i_pair_wr;
  assign byte_rd_en = bus.i_reg_rd & ~pair_any;
  assign byte_wr_en = bus.i_reg_wr & ~pair_any;

  always_comb begin
    byte_sel = '0;
    pair_sel = '0;
    case (bus.i_reg_addr)
      REG_B:   byte_sel = reg_b;
      REG_C:   byte_sel = reg_c;
      REG_D:   byte_sel = reg_d;
      REG_E:   byte_sel = reg_e;
      REG_H:   byte_sel = reg_h;
      REG_L:   byte_sel = reg_l;
      default: byte_sel = '0;
    endcase
    case (bus.i_reg_addr)
      PAIR_BC: pair_sel = {reg_b, reg_c};
      PAIR_DE: pair_sel = {reg_d, reg_e};
      PAIR_HL: pair_sel = {reg_h, reg_l};
      PAIR_PC: pair_sel = pc;
      PAIR_SP: pair_sel = sp;
      default: pair_sel = '0;
    endcase
  end

  gb80_pair_incdec #(.PTR_WIDTH(PTR_WIDTH)) u_incdec (
    .cur      (pair_sel),
    .op       (pair_op_t'(bus.i_pair_op)),
    .load_val (bus.i_addr_in),
    .nxt      (pair_nxt)
  );

  // Reads see pre-edge state, so PC_INC returns the old PC while it advances.
  assign bus.o_data_out   = byte_rd_en ? byte_sel : '0;
  assign bus.o_data_valid = byte_rd_en;
  assign bus.o_addr_out   = bus.i_pair_rd ? pair_sel : '0;
  assign bus.o_addr_valid = bus.i_pair_rd;
  assign bus.o_conflict   = conflict_q;
  assign bus.o_pc         = pc;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      reg_b      <= '0;
      reg_c      <= '0;
      reg_d      <= '0;
      reg_e      <= '0;
      reg_h      <= '0;
      reg_l      <= '0;
      pc         <= PC_RESET;
      sp         <= SP_RESET;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= (bus.i_reg_rd | bus.i_reg_wr) & pair_any;
      if (byte_wr_en) begin
        case (bus.i_reg_addr)
          REG_B:   reg_b <= bus.i_data_in;
          REG_C:   reg_c <= bus.i_data_in;
          REG_D:   reg_d <= bus.i_data_in;
          REG_E:   reg_e <= bus.i_data_in;
          REG_H:   reg_h <= bus.i_data_in;
          REG_L:   reg_l <= bus.i_data_in;
          default: ;
        endcase
      end
      if (bus.i_pair_wr) begin
        case (bus.i_reg_addr)
          PAIR_BC: {reg_b, reg_c} <= pair_nxt;
          PAIR_DE: {reg_d, reg_e} <= pair_nxt;
          PAIR_HL: {reg_h, reg_l} <= pair_nxt;
          PAIR_PC: pc <= pair_nxt;
          PAIR_SP: sp <= pair_nxt;
          default: ;
        endcase
      end
    end
  end

endmodule
